// File: rtl/codec_i2s_intf.sv
// I2S link to the audio codec: clock generation, codec reset sequencing,
// 24-bit ADC deserialisation and 16-bit DAC serialisation.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_HOLD | codec held in reset until the first full frame has elapsed
//   ST_WAKE | codec released this frame; received data not yet trusted
//   ST_RUN  | normal operation, vld pulses once per frame
module codec_i2s_intf #(
    parameter int SCLK_LOG2 = 5,
    parameter int IN_W      = 24,
    parameter int OUT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SDout,
    input  logic [OUT_W-1:0]  aud_out_lft,
    input  logic [OUT_W-1:0]  aud_out_rght,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              codec_rst_n,
    output logic              SDin,
    output logic [IN_W-1:0]   aud_in_lft,
    output logic [IN_W-1:0]   aud_in_rght,
    output logic              vld
);
    localparam int CW = SCLK_LOG2 + 6;
    localparam logic [4:0]           RX_LAST   = 5'(IN_W);
    localparam logic [4:0]           TX_LAST   = 5'(OUT_W);
    localparam logic [SCLK_LOG2-1:0] PH_SAMPLE = {1'b0, {(SCLK_LOG2-1){1'b1}}};
    localparam logic [SCLK_LOG2-1:0] PH_LAST   = '1;

    typedef enum logic [1:0] {ST_HOLD, ST_WAKE, ST_RUN} seq_t;

    seq_t                 state;
    logic [CW-1:0]        cnt;
    logic [4:0]           slot;
    logic [SCLK_LOG2-1:0] phase;
    logic                 half_end;
    logic                 frame_end;
    logic                 rx_take;
    logic [IN_W-1:0]      rx_shift;
    logic [IN_W-1:0]      rx_next;
    logic [IN_W-1:0]      lft_hold;
    logic [OUT_W-1:0]     tx_shift;

    assign slot      = cnt[SCLK_LOG2+4:SCLK_LOG2];
    assign phase     = cnt[SCLK_LOG2-1:0];
    assign half_end  = (cnt[SCLK_LOG2+4:0] == '1);
    assign frame_end = (cnt == '1);

    assign MCLK  = cnt[1];
    assign SCLK  = cnt[SCLK_LOG2-1];
    assign LRCLK = cnt[CW-1];

    // Sample on the last clk before SCLK rises; slot 0 is the I2S delay bit.
    assign rx_take = (phase == PH_SAMPLE) && (slot != 5'd0) && (slot <= RX_LAST);
    assign rx_next = {rx_shift[IN_W-2:0], SDout};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            state       <= ST_HOLD;
            codec_rst_n <= 1'b0;
        end else begin
            cnt <= cnt + CW'(1);
            case (state)
                ST_HOLD: if (frame_end) begin
                    state       <= ST_WAKE;
                    codec_rst_n <= 1'b1;
                end
                ST_WAKE: if (frame_end) state <= ST_RUN;
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift    <= '0;
            lft_hold    <= '0;
            aud_in_lft  <= '0;
            aud_in_rght <= '0;
            vld         <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (rx_take) begin
                rx_shift <= rx_next;
                if (slot == RX_LAST) begin
                    if (!LRCLK) begin
                        lft_hold <= rx_next;
                    end else begin
                        aud_in_lft  <= lft_hold;
                        aud_in_rght <= rx_next;
                        vld         <= (state == ST_RUN);
                    end
                end
            end
        end
    end

    // The output word is latched only at half boundaries, so engine updates
    // mid-half never disturb the word currently on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '0;
            SDin     <= 1'b0;
        end else if (phase == PH_LAST) begin
            if (half_end) begin
                tx_shift <= LRCLK ? aud_out_lft : aud_out_rght;
                SDin     <= 1'b0;
            end else if (slot < TX_LAST) begin
                SDin     <= tx_shift[OUT_W-1];
                tx_shift <= {tx_shift[OUT_W-2:0], 1'b0};
            end else begin
                SDin <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_codec_i2s_intf.sv
// Bench for codec_i2s_intf: codec ADC model, vld/data scoreboard and a
// per-half DAC word scoreboard, plus clock and reset sequencing checks.
module tb_codec_i2s_intf;
    logic        clk = 1'b0;
    logic        rst;
    logic        SDout = 1'b0;
    logic [15:0] aud_out_lft;
    logic [15:0] aud_out_rght;
    logic        MCLK, SCLK, LRCLK, codec_rst_n, SDin, vld;
    logic [23:0] aud_in_lft, aud_in_rght;

    logic [23:0] codec_l, codec_r;
    logic [31:0] cyc   = '0;
    logic        rst_q = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] at;
        logic [23:0] l;
        logic [23:0] r;
    } vexp_t;

    vexp_t       vq[$];
    logic [31:0] txq[$];

    codec_i2s_intf dut (
        .clk          (clk),
        .rst          (rst),
        .SDout        (SDout),
        .aud_out_lft  (aud_out_lft),
        .aud_out_rght (aud_out_rght),
        .MCLK         (MCLK),
        .SCLK         (SCLK),
        .LRCLK        (LRCLK),
        .codec_rst_n  (codec_rst_n),
        .SDin         (SDin),
        .aud_in_lft   (aud_in_lft),
        .aud_in_rght  (aud_in_rght),
        .vld          (vld)
    );

    always #5 clk = ~clk;

    // cyc counts clocks since rst was last released; cyc == 0 is cnt == 0.
    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) cyc <= '0;
        else     cyc <= cyc + 32'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] tx_pat(input logic [15:0] v);
        return {1'b0, v, 15'h0};
    endfunction

    task automatic push_v(input logic [31:0] at, input logic [23:0] l, input logic [23:0] r);
        vexp_t e;
        e.at = at;
        e.l  = l;
        e.r  = r;
        vq.push_back(e);
    endtask

    task automatic wait_cyc(input logic [31:0] t);
        int guard = 0;
        while (cyc != t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_timeout: cycle %0d, expected to reach %0d", cyc, t);
        end
    endtask

    // Codec ADC: MSB in slot 1 of each half, idle zeros in slots 0 and 25..31.
    always @(negedge clk) begin
        int s;
        logic [23:0] w;
        s = int'(cyc[9:5]);
        w = cyc[10] ? codec_r : codec_l;
        SDout = (s >= 1 && s <= 24) ? w[24 - s] : 1'b0;
    end

    // Expected DAC word for each half: the engine value present at the half start.
    always @(negedge clk) begin
        if (cyc[9:0] == 10'd0) begin
            if (rst_q) begin
                txq.delete();
                txq.push_back(32'h0);
            end else begin
                txq.push_back(tx_pat(cyc[10] ? aud_out_rght : aud_out_lft));
            end
        end
    end

    // DAC monitor: one SDin sample mid-slot, compare after slot 31.
    always @(negedge clk) begin
        logic [31:0] acc;
        logic [31:0] e;
        if (rst_q) acc = '0;
        if (cyc[4:0] == 5'd16) begin
            acc[31 - int'(cyc[9:5])] = SDin;
            if (cyc[9:5] == 5'd31) begin
                if (txq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sdin_unexpected: word %h with no expectation", acc);
                end else begin
                    e = txq.pop_front();
                    chk(cyc[10] ? "sdin_right_word" : "sdin_left_word", 64'(acc), 64'(e));
                end
            end
        end
    end

    // RX monitor: every vld must match the next expectation in time and data.
    always @(negedge clk) begin
        vexp_t e;
        if (vld) begin
            if (vq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL vld_unexpected: vld at cycle %0d, expected none", cyc);
            end else begin
                e = vq.pop_front();
                chk("vld_cycle",   64'(cyc),         64'(e.at));
                chk("aud_in_lft",  64'(aud_in_lft),  64'(e.l));
                chk("aud_in_rght", 64'(aud_in_rght), 64'(e.r));
            end
        end else if (vq.size() != 0 && cyc > vq[0].at) begin
            n_cmp++;
            n_err++;
            $display("FAIL vld_missing: no vld by cycle %0d, expected at %0d", cyc, vq[0].at);
            void'(vq.pop_front());
        end
    end

    initial begin
        int mh, sh, lh, mr, sr, lr;
        logic pm, ps, pl;

        rst          = 1'b1;
        aud_out_lft  = 16'h8001;
        aud_out_rght = 16'h7FFE;
        codec_l      = 24'hA5C3F1;
        codec_r      = 24'h123456;
        repeat (10) @(negedge clk);
        chk("reset_outputs",
            64'({MCLK, SCLK, LRCLK, codec_rst_n, SDin, vld, aud_in_lft, aud_in_rght}), 64'h0);

        push_v(32'd5904,  24'hA5C3F1, 24'h123456);
        push_v(32'd7952,  24'hA5C3F1, 24'h123456);
        push_v(32'd10000, 24'h800000, 24'hFFFFFF);
        push_v(32'd12048, 24'h800000, 24'hFFFFFF);
        rst = 1'b0;

        mh = 0; sh = 0; lh = 0; mr = 0; sr = 0; lr = 0;
        pm = 1'b0; ps = 1'b0; pl = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) @(negedge clk);
            if (MCLK)  mh++;
            if (SCLK)  sh++;
            if (LRCLK) lh++;
            if (MCLK && !pm)  mr++;
            if (SCLK && !ps)  sr++;
            if (LRCLK && !pl) lr++;
            pm = MCLK;
            ps = SCLK;
            pl = LRCLK;
            if (i == 2047) chk("codec_rst_n_before", 64'(codec_rst_n), 64'd0);
            if (i == 2048) chk("codec_rst_n_rise",   64'(codec_rst_n), 64'd1);
        end
        chk("mclk_rises",  64'(mr), 64'd1024);
        chk("sclk_rises",  64'(sr), 64'd128);
        chk("lrclk_rises", 64'(lr), 64'd2);
        chk("mclk_high",   64'(mh), 64'd2048);
        chk("sclk_high",   64'(sh), 64'd2048);
        chk("lrclk_high",  64'(lh), 64'd2048);

        // Engine changes its left word in the middle of frame 3's left half.
        wait_cyc(32'd6644);
        aud_out_lft = 16'h1234;

        wait_cyc(32'd8192);
        codec_l = 24'h800000;
        codec_r = 24'hFFFFFF;

        // One-clock reset in the middle of frame 6, before its vld.
        wait_cyc(32'd13788);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outputs",
            64'({codec_rst_n, SDin, vld, aud_in_lft, aud_in_rght}), 64'h0);
        push_v(32'd5904, 24'h800000, 24'hFFFFFF);
        push_v(32'd7952, 24'h800000, 24'hFFFFFF);

        wait_cyc(32'd2047);
        chk("midrst_codec_rst_n_low",  64'(codec_rst_n), 64'd0);
        wait_cyc(32'd2048);
        chk("midrst_codec_rst_n_high", 64'(codec_rst_n), 64'd1);

        wait_cyc(32'd8100);
        chk("vld_queue_drained", 64'(vq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
